// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream handshake between the UART receive/transmit side and the command decoder.
// The decoder attaches through the slave modport; the UART side uses master.
interface uart_cmd_decoder_if;
    logic [7:0] rx_data_i;
    logic       rx_done_i;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;

    modport master (
        output rx_data_i, rx_done_i, tx_ready_i,
        input  tx_data_o, tx_valid_o
    );

    modport slave (
        input  rx_data_i, rx_done_i, tx_ready_i,
        output tx_data_o, tx_valid_o
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Assembles 5-byte SYNC/CMD/ADDR/DATA/CSUM frames from the UART receiver, updates a
// 4x8-bit config bank and queues a one-byte ACK/NAK/read-data response.
module uart_cmd_decoder #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [19:0] TIMEOUT_CYC = 20'd260400,
    parameter logic [31:0] CFG_RESET   = 32'h00000000,
    parameter logic [7:0]  ACK_BYTE    = 8'h06,
    parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    uart_cmd_decoder_if.slave    bus,
    output logic [31:0]          cfg_o,
    output logic                 cfg_wr_o,
    output logic [1:0]           cfg_addr_o,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [1:0]           err_code_o
);

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CSUM,
        S_RESP
    } state_t;

    state_t      r_state,   w_stateNext;
    logic [7:0]  r_cmd,     w_cmdNext;
    logic [7:0]  r_addr,    w_addrNext;
    logic [7:0]  r_data,    w_dataNext;
    logic [19:0] r_timer,   w_timerNext;
    logic [31:0] r_cfg,     w_cfgNext;
    logic        r_cfgWr,   w_cfgWrNext;
    logic [1:0]  r_cfgAddr, w_cfgAddrNext;
    logic        r_err,     w_errNext;
    logic [1:0]  r_errCode, w_errCodeNext;
    logic        r_txValid, w_txValidNext;
    logic [7:0]  r_txData,  w_txDataNext;

    logic [7:0]  w_sum;
    logic        w_inFrame;
    logic [4:0]  w_byteSel;

    assign w_sum     = r_cmd + r_addr + r_data;
    assign w_inFrame = (r_state == S_CMD) || (r_state == S_ADDR) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_byteSel = {r_addr[1:0], 3'b000};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cmd     <= 8'h00;
            r_addr    <= 8'h00;
            r_data    <= 8'h00;
            r_timer   <= 20'd0;
            r_cfg     <= CFG_RESET;
            r_cfgWr   <= 1'b0;
            r_cfgAddr <= 2'd0;
            r_err     <= 1'b0;
            r_errCode <= 2'd0;
            r_txValid <= 1'b0;
            r_txData  <= 8'h00;
        end else begin
            r_state   <= w_stateNext;
            r_cmd     <= w_cmdNext;
            r_addr    <= w_addrNext;
            r_data    <= w_dataNext;
            r_timer   <= w_timerNext;
            r_cfg     <= w_cfgNext;
            r_cfgWr   <= w_cfgWrNext;
            r_cfgAddr <= w_cfgAddrNext;
            r_err     <= w_errNext;
            r_errCode <= w_errCodeNext;
            r_txValid <= w_txValidNext;
            r_txData  <= w_txDataNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_cmdNext     = r_cmd;
        w_addrNext    = r_addr;
        w_dataNext    = r_data;
        w_timerNext   = 20'd0;
        w_cfgNext     = r_cfg;
        w_cfgWrNext   = 1'b0;
        w_cfgAddrNext = r_cfgAddr;
        w_errNext     = 1'b0;
        w_errCodeNext = r_errCode;
        w_txValidNext = r_txValid;
        w_txDataNext  = r_txData;

        case (r_state)
            S_IDLE: begin
                if (bus.rx_done_i && (bus.rx_data_i == SYNC_BYTE)) w_stateNext = S_CMD;
            end
            S_CMD: begin
                if (bus.rx_done_i) begin
                    w_cmdNext   = bus.rx_data_i;
                    w_stateNext = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bus.rx_done_i) begin
                    w_addrNext  = bus.rx_data_i;
                    w_stateNext = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.rx_done_i) begin
                    w_dataNext  = bus.rx_data_i;
                    w_stateNext = S_CSUM;
                end
            end
            S_CSUM: begin
                // Checksum failure outranks a bad command/address.
                if (bus.rx_done_i) begin
                    w_stateNext   = S_RESP;
                    w_txValidNext = 1'b1;
                    if (w_sum != bus.rx_data_i) begin
                        w_txDataNext  = NAK_BYTE;
                        w_errNext     = 1'b1;
                        w_errCodeNext = 2'd1;
                    end else if (((r_cmd != CMD_WRITE) && (r_cmd != CMD_READ)) || (r_addr > 8'd3)) begin
                        w_txDataNext  = NAK_BYTE;
                        w_errNext     = 1'b1;
                        w_errCodeNext = 2'd2;
                    end else if (r_cmd == CMD_WRITE) begin
                        w_cfgNext[w_byteSel +: 8] = r_data;
                        w_cfgWrNext   = 1'b1;
                        w_cfgAddrNext = r_addr[1:0];
                        w_txDataNext  = ACK_BYTE;
                    end else begin
                        w_txDataNext  = r_cfg[w_byteSel +: 8];
                    end
                end
            end
            S_RESP: begin
                if (r_txValid && bus.tx_ready_i) begin
                    w_stateNext   = S_IDLE;
                    w_txValidNext = 1'b0;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase

        // A byte arriving on the limit cycle wins; only true silence aborts the frame.
        if (w_inFrame && !bus.rx_done_i) begin
            if (r_timer == TIMEOUT_CYC - 20'd1) begin
                w_stateNext   = S_IDLE;
                w_errNext     = 1'b1;
                w_errCodeNext = 2'd3;
            end else begin
                w_timerNext = r_timer + 20'd1;
            end
        end
    end

    assign bus.tx_data_o  = r_txData;
    assign bus.tx_valid_o = r_txValid;
    assign cfg_o          = r_cfg;
    assign cfg_wr_o       = r_cfgWr;
    assign cfg_addr_o     = r_cfgAddr;
    assign err_o          = r_err;
    assign err_code_o     = r_errCode;
    assign busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized self-checking bench for uart_cmd_decoder against a frame-level model of
// the config bank, response byte and error code.
module tb_uart_cmd_decoder;

    localparam logic [19:0] TO   = 20'd40;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] cfg_o;
    logic        cfg_wr_o;
    logic [1:0]  cfg_addr_o;
    logic        busy_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    int tests = 0;
    int fails = 0;

    logic [7:0] mCfg [4];
    logic [1:0] mAddr;
    logic [1:0] mCode;

    always #5 clk_i = ~clk_i;

    uart_cmd_decoder_if bus();

    uart_cmd_decoder #(.TIMEOUT_CYC(TO)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus        (bus.slave),
        .cfg_o      (cfg_o),
        .cfg_wr_o   (cfg_wr_o),
        .cfg_addr_o (cfg_addr_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .err_code_o (err_code_o)
    );

    function automatic logic [31:0] modelCfg();
        return {mCfg[3], mCfg[2], mCfg[1], mCfg[0]};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) mCfg[i] = 8'h00;
        mAddr = 2'd0;
        mCode = 2'd0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(posedge clk_i); #1;
        bus.rx_data_i = b;
        bus.rx_done_i = 1'b1;
        @(posedge clk_i); #1;
        bus.rx_done_i = 1'b0;
    endtask

    // Sends one frame, predicts its outcome from the frame rules and checks response and handshake.
    task automatic doFrame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] data,
                           input logic [7:0] csum, input int gap, input int readyDelay);
        logic [7:0]  sum, expTx;
        logic        expWr, expErr;
        logic [31:0] expCfg;
        sum = cmd + addr + data;
        expWr = 1'b0;
        expErr = 1'b0;
        if (sum != csum) begin
            expTx = 8'h15; expErr = 1'b1; mCode = 2'd1;
        end else if ((cmd != 8'h01 && cmd != 8'h02) || addr > 8'd3) begin
            expTx = 8'h15; expErr = 1'b1; mCode = 2'd2;
        end else if (cmd == 8'h01) begin
            mCfg[addr[1:0]] = data; mAddr = addr[1:0]; expWr = 1'b1; expTx = 8'h06;
        end else begin
            expTx = mCfg[addr[1:0]];
        end
        expCfg = modelCfg();

        bus.tx_ready_i = (readyDelay == 0);
        sendByte(SYNC);
        repeat (gap) @(posedge clk_i);
        sendByte(cmd);
        repeat (gap) @(posedge clk_i);
        sendByte(addr);
        repeat (gap) @(posedge clk_i);
        sendByte(data);
        repeat (gap) @(posedge clk_i);
        sendByte(csum);

        tests++;
        if (bus.tx_valid_o !== 1'b1) begin fails++; $display("[TB] FAIL tx_valid: got %b expected 1", bus.tx_valid_o); end
        tests++;
        if (bus.tx_data_o !== expTx) begin fails++; $display("[TB] FAIL tx_data: got %h expected %h", bus.tx_data_o, expTx); end
        tests++;
        if (cfg_o !== expCfg) begin fails++; $display("[TB] FAIL cfg: got %h expected %h", cfg_o, expCfg); end
        tests++;
        if (cfg_wr_o !== expWr) begin fails++; $display("[TB] FAIL cfg_wr: got %b expected %b", cfg_wr_o, expWr); end
        tests++;
        if (err_o !== expErr) begin fails++; $display("[TB] FAIL err: got %b expected %b", err_o, expErr); end
        tests++;
        if (err_code_o !== mCode) begin fails++; $display("[TB] FAIL err_code: got %0d expected %0d", err_code_o, mCode); end
        tests++;
        if (cfg_addr_o !== mAddr) begin fails++; $display("[TB] FAIL cfg_addr: got %0d expected %0d", cfg_addr_o, mAddr); end

        for (int i = 0; i < readyDelay; i++) begin
            @(posedge clk_i); #1;
            tests++;
            if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== expTx || cfg_wr_o !== 1'b0 || err_o !== 1'b0) begin
                fails++;
                $display("[TB] FAIL resp_hold: valid=%b data=%h wr=%b err=%b expected 1/%h/0/0",
                         bus.tx_valid_o, bus.tx_data_o, cfg_wr_o, err_o, expTx);
            end
            if (i == readyDelay - 1) bus.tx_ready_i = 1'b1;
        end
        @(posedge clk_i); #1;
        tests++;
        if (bus.tx_valid_o !== 1'b0 || busy_o !== 1'b0 || cfg_wr_o !== 1'b0 || err_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL resp_done: valid=%b busy=%b wr=%b err=%b expected all 0",
                     bus.tx_valid_o, busy_o, cfg_wr_o, err_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        modelReset();
        tests++;
        if (bus.tx_valid_o !== 1'b0 || bus.tx_data_o !== 8'h00 || cfg_o !== 32'h0 || cfg_wr_o !== 1'b0 ||
            cfg_addr_o !== 2'd0 || err_o !== 1'b0 || err_code_o !== 2'd0 || busy_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_state: valid=%b data=%h cfg=%h wr=%b addr=%0d err=%b code=%0d busy=%b expected all 0",
                     bus.tx_valid_o, bus.tx_data_o, cfg_o, cfg_wr_o, cfg_addr_o, err_o, err_code_o, busy_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_directed();
        doFrame(8'h01, 8'h02, 8'h3C, 8'h3F, 0, 0);
        tests++;
        if (cfg_o !== 32'h003C0000) begin fails++; $display("[TB] FAIL directed_write_cfg: got %h expected 003c0000", cfg_o); end
        doFrame(8'h02, 8'h02, 8'h00, 8'h04, 1, 0);
        doFrame(8'h01, 8'h01, 8'h55, 8'h00, 0, 0);
        doFrame(8'h03, 8'h00, 8'h00, 8'h03, 0, 1);
        doFrame(8'h01, 8'h04, 8'h11, 8'h16, 2, 0);
        tests++;
        if (cfg_o !== 32'h003C0000) begin fails++; $display("[TB] FAIL directed_cfg_kept: got %h expected 003c0000", cfg_o); end
    endtask

    task automatic test_random();
        logic [7:0] cmd, addr, data, csum;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: cmd = 8'h01;
                4, 5, 6, 7: cmd = 8'h02;
                default:    cmd = 8'($urandom);
            endcase
            addr = 8'($urandom_range(0, 5));
            data = 8'($urandom);
            csum = cmd + addr + data;
            if ($urandom_range(0, 4) == 0) csum = csum + 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) begin
                sendByte(8'h5A);
                tests++;
                if (busy_o !== 1'b0) begin fails++; $display("[TB] FAIL idle_junk: busy got %b expected 0", busy_o); end
            end
            doFrame(cmd, addr, data, csum, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] addr, data;
        for (int n = 0; n < 8; n++) begin
            addr = 8'($urandom_range(0, 3));
            data = 8'($urandom);
            if (n % 2 == 0) doFrame(8'h01, addr, data, 8'h01 + addr + data, 0, 0);
            else            doFrame(8'h02, addr, data, 8'h02 + addr + data, 0, 0);
        end
    endtask

    task automatic test_timeout();
        int  errAt;
        bit  sawValid;
        errAt = -1;
        sawValid = 1'b0;
        bus.tx_ready_i = 1'b1;
        sendByte(SYNC);
        sendByte(8'h01);
        for (int k = 1; k <= int'(TO) + 10; k++) begin
            @(posedge clk_i); #1;
            if (bus.tx_valid_o) sawValid = 1'b1;
            if (err_o) begin errAt = k; break; end
        end
        mCode = 2'd3;
        tests++;
        if (errAt != int'(TO)) begin fails++; $display("[TB] FAIL timeout_cycle: got %0d expected %0d", errAt, TO); end
        tests++;
        if (err_code_o !== 2'd3 || busy_o !== 1'b0 || sawValid || cfg_o !== modelCfg()) begin
            fails++;
            $display("[TB] FAIL timeout_state: code=%0d busy=%b valid_seen=%b cfg=%h expected 3/0/0/%h",
                     err_code_o, busy_o, sawValid, cfg_o, modelCfg());
        end
        @(posedge clk_i); #1;
        tests++;
        if (err_o !== 1'b0) begin fails++; $display("[TB] FAIL timeout_pulse: err got %b expected 0", err_o); end
        doFrame(8'h01, 8'h00, 8'h9C, 8'h9D, int'(TO) - 2, 0);
        doFrame(8'h01, 8'h03, 8'h42, 8'h46, 0, 0);
    endtask

    task automatic test_resp_reset();
        bus.tx_ready_i = 1'b0;
        sendByte(SYNC);
        sendByte(8'h01);
        sendByte(8'h03);
        sendByte(8'h77);
        sendByte(8'h7B);
        tests++;
        if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'h06) begin
            fails++; $display("[TB] FAIL resp_start: valid=%b data=%h expected 1/06", bus.tx_valid_o, bus.tx_data_o);
        end
        for (int i = 0; i < 10; i++) begin
            sendByte((i == 3) ? SYNC : 8'($urandom));
            tests++;
            if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'h06 || busy_o !== 1'b1) begin
                fails++;
                $display("[TB] FAIL resp_stall: valid=%b data=%h busy=%b expected 1/06/1", bus.tx_valid_o, bus.tx_data_o, busy_o);
            end
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        modelReset();
        tests++;
        if (bus.tx_valid_o !== 1'b0 || cfg_o !== 32'h0 || busy_o !== 1'b0 || err_code_o !== 2'd0) begin
            fails++;
            $display("[TB] FAIL resp_reset: valid=%b cfg=%h busy=%b code=%0d expected 0/0/0/0",
                     bus.tx_valid_o, cfg_o, busy_o, err_code_o);
        end
        doFrame(8'h02, 8'h03, 8'h00, 8'h05, 0, 0);
    endtask

    initial begin
        bus.rx_data_i  = 8'h00;
        bus.rx_done_i  = 1'b0;
        bus.tx_ready_i = 1'b0;
        rst_i          = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_timeout();
        test_resp_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
